// File: rtl/mc_inj_seq_pkg.sv
// Shared definitions for the multicast inject/eject sequencers: port indices,
// destination-list region masks, sequencer state encoding and a popcount helper.
package mc_inj_seq_pkg;

  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_S = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  // Network ports occupy the indices below the local port.
  localparam int NUM_PORT       = P_L;
  localparam int DST_LIST_WIDTH = 20;

  localparam logic [DST_LIST_WIDTH-1:0] N_MASK = 20'h0000F;
  localparam logic [DST_LIST_WIDTH-1:0] E_MASK = 20'h000F0;
  localparam logic [DST_LIST_WIDTH-1:0] S_MASK = 20'h00F00;
  localparam logic [DST_LIST_WIDTH-1:0] W_MASK = 20'h0F000;
  localparam logic [DST_LIST_WIDTH-1:0] L_MASK = 20'hF0000;

  localparam logic [DST_LIST_WIDTH-1:0] PROD_MASK = N_MASK | E_MASK | S_MASK | W_MASK;

  localparam logic [NUM_PORT-1:0][DST_LIST_WIDTH-1:0] PORT_MASK =
    {W_MASK, S_MASK, E_MASK, N_MASK};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01
  } seq_state_e;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/mc_port_req.sv
// Splits a remaining destination list into per-port requests, granted replica
// lists and the mask of regions retired by this cycle's effective grant.
module mc_port_req
  import mc_inj_seq_pkg::*;
#(
  parameter int DST_W = DST_LIST_WIDTH
) (
  input  logic [DST_W-1:0]                 dst,
  input  logic [NUM_PORT-1:0]              gnt,
  output logic [NUM_PORT-1:0]              req,
  output logic [NUM_PORT-1:0]              eff_gnt,
  output logic [NUM_PORT-1:0][DST_W-1:0]   port_dst,
  output logic [DST_W-1:0]                 retire
);

  logic [NUM_PORT-1:0][DST_W-1:0] region;

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    assign region[p]   = dst & DST_W'(PORT_MASK[p]);
    assign req[p]      = |region[p];
    // Grants on ports we did not request are ignored entirely.
    assign eff_gnt[p]  = gnt[p] & req[p];
    assign port_dst[p] = eff_gnt[p] ? region[p] : '0;
  end

  always_comb begin
    retire = '0;
    for (int p = 0; p < NUM_PORT; p++)
      if (eff_gnt[p]) retire = retire | DST_W'(PORT_MASK[p]);
  end

endmodule

// File: rtl/mc_inj_seq.sv
// Injection-side multicast sequencer: holds one PE flit, requests every
// productive port, retires granted regions and flags starvation.
module mc_inj_seq
  import mc_inj_seq_pkg::*;
#(
  parameter int FLIT_W        = 64,
  parameter int DST_W         = DST_LIST_WIDTH,
  parameter int STARVE_THRESH = 8,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DST_W-1:0]  in_dst,
  input  logic [FLIT_W-1:0] in_data,
  output logic [3:0]        req_o,
  input  logic [3:0]        gnt_i,
  output logic [FLIT_W-1:0] out_data,
  output logic [DST_W-1:0]  out_dst_n,
  output logic [DST_W-1:0]  out_dst_e,
  output logic [DST_W-1:0]  out_dst_s,
  output logic [DST_W-1:0]  out_dst_w,
  output logic              starve_o,
  output logic              drop_o,
  output logic [15:0]       rep_cnt
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(STARVE_THRESH);
  localparam logic [DST_W-1:0] PROD   = DST_W'(PROD_MASK);

  seq_state_e                     state, state_nxt;
  logic [DST_W-1:0]               dst_rem, dst_nxt, dst_act, retire;
  logic [FLIT_W-1:0]              data_nxt;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic [15:0]                    rep_nxt;
  logic                           drop_nxt;
  logic [NUM_PORT-1:0]            eff_gnt;
  logic [NUM_PORT-1:0][DST_W-1:0] port_dst;

  // Outside ISSUE the leftover list (L bits, dropped flit) must not request.
  assign dst_act = (state == ISSUE) ? dst_rem : '0;

  mc_port_req #(.DST_W(DST_W)) u_port_req (
    .dst      (dst_act),
    .gnt      (gnt_i),
    .req      (req_o),
    .eff_gnt  (eff_gnt),
    .port_dst (port_dst),
    .retire   (retire)
  );

  assign in_ready  = (state == IDLE);
  assign out_dst_n = port_dst[P_N];
  assign out_dst_e = port_dst[P_E];
  assign out_dst_s = port_dst[P_S];
  assign out_dst_w = port_dst[P_W];

  always_comb begin
    state_nxt = state;
    dst_nxt   = dst_rem;
    data_nxt  = out_data;
    cnt_nxt   = cnt;
    rep_nxt   = rep_cnt;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (in_valid) begin
          dst_nxt  = in_dst;
          data_nxt = in_data;
          if (|(in_dst & PROD)) state_nxt = ISSUE;
          else                  drop_nxt  = 1'b1;
        end
      end
      ISSUE: begin
        dst_nxt = dst_rem & ~retire;
        rep_nxt = rep_cnt + {13'd0, popcnt4(eff_gnt)};
        if (|eff_gnt)          cnt_nxt = '0;
        else if (cnt != THRESH) cnt_nxt = cnt + 1'b1;
        if (!(|(dst_nxt & PROD))) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_rem  <= '0;
      out_data <= '0;
      cnt      <= '0;
      starve_o <= 1'b0;
      drop_o   <= 1'b0;
      rep_cnt  <= '0;
    end else begin
      dst_rem  <= dst_nxt;
      out_data <= data_nxt;
      cnt      <= cnt_nxt;
      starve_o <= (cnt_nxt == THRESH);
      drop_o   <= drop_nxt;
      rep_cnt  <= rep_nxt;
    end
  end

endmodule

// File: tb/tb_mc_inj_seq.sv
// Directed and randomized checks of mc_inj_seq against a list-level model of
// the multicast injection rules.
module tb_mc_inj_seq;

  localparam int FW = 64;
  localparam int DW = 20;
  localparam int TH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dst = '0;
  logic [FW-1:0] in_data = '0;
  logic [3:0]    req_o;
  logic [3:0]    gnt_i = '0;
  logic [FW-1:0] out_data;
  logic [DW-1:0] out_dst_n, out_dst_e, out_dst_s, out_dst_w;
  logic          starve_o, drop_o;
  logic [15:0]   rep_cnt;

  mc_inj_seq #(.FLIT_W(FW), .DST_W(DW), .STARVE_THRESH(TH), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst), .in_data(in_data),
    .req_o(req_o), .gnt_i(gnt_i), .out_data(out_data),
    .out_dst_n(out_dst_n), .out_dst_e(out_dst_e), .out_dst_s(out_dst_s), .out_dst_w(out_dst_w),
    .starve_o(starve_o), .drop_o(drop_o), .rep_cnt(rep_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] region_mask [4] = '{20'h0000F, 20'h000F0, 20'h00F00, 20'h0F000};
  logic [DW-1:0] net_mask = 20'h0FFFF;

  // Model: a flit is "outstanding" while network destinations remain.
  bit            m_busy;
  logic [DW-1:0] m_rem;
  logic [FW-1:0] m_data;
  logic [15:0]   m_rep;
  int            m_wait;
  bit            m_starve, m_drop;

  task automatic model_reset();
    m_busy = 0; m_rem = '0; m_data = '0; m_rep = '0;
    m_wait = 0; m_starve = 0; m_drop = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check before posedge, advance model at posedge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [FW-1:0] dat,
                     input logic [3:0] g);
    logic [3:0]    req, eg;
    logic [DW-1:0] exp_dst [4];
    in_valid = v; in_dst = d; in_data = dat; gnt_i = g;
    #1;
    for (int i = 0; i < 4; i++) begin
      req[i]     = m_busy && ((m_rem & region_mask[i]) != '0);
      eg[i]      = g[i] && req[i];
      exp_dst[i] = eg[i] ? (m_rem & region_mask[i]) : '0;
    end
    chk("in_ready",  64'(in_ready),  64'(!m_busy));
    chk("req_o",     64'(req_o),     64'(req));
    chk("out_dst_n", 64'(out_dst_n), 64'(exp_dst[0]));
    chk("out_dst_e", 64'(out_dst_e), 64'(exp_dst[1]));
    chk("out_dst_s", 64'(out_dst_s), 64'(exp_dst[2]));
    chk("out_dst_w", 64'(out_dst_w), 64'(exp_dst[3]));
    chk("out_data",  out_data,       m_data);
    chk("starve_o",  64'(starve_o),  64'(m_starve));
    chk("drop_o",    64'(drop_o),    64'(m_drop));
    chk("rep_cnt",   64'(rep_cnt),   64'(m_rep));
    @(posedge clk);
    m_drop = 0;
    if (m_busy) begin
      for (int i = 0; i < 4; i++) if (eg[i]) m_rem = m_rem & ~region_mask[i];
      m_rep  = m_rep + 16'($countones(eg));
      m_wait = (eg == 4'd0) ? m_wait + 1 : 0;
      m_starve = (m_wait >= TH);
      if ((m_rem & net_mask) == '0) begin
        m_busy = 0; m_wait = 0; m_starve = 0;
      end
    end else if (v) begin
      m_rem = d; m_data = dat;
      if ((d & net_mask) != '0) m_busy = 1;
      else                      m_drop = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [3:0]    rg;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req",      64'(req_o),    64'd0);
    chk("rst_rep",      64'(rep_cnt),  64'd0);
    chk("rst_starve",   64'(starve_o), 64'd0);
    chk("rst_drop",     64'(drop_o),   64'd0);
    chk("rst_data",     out_data,      64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unicast east
    cyc(1, 20'h00010, 64'hA5A5_0000_0000_0001, 4'b0000);
    cyc(0, '0, '0, 4'b0010);
    chk("uni_rep",   64'(rep_cnt),  64'd1);
    chk("uni_ready", 64'(in_ready), 64'd1);
    cyc(0, '0, '0, 4'b0000);

    // Partial grants over three cycles
    cyc(1, 20'h01231, 64'hDEAD_BEEF_0123_4567, 4'b0000);
    cyc(0, '0, '0, 4'b0001);
    cyc(0, '0, '0, 4'b0100);
    cyc(0, '0, '0, 4'b1010);
    chk("part_rep",   64'(rep_cnt),  64'd5);
    chk("part_ready", 64'(in_ready), 64'd1);

    // Starvation on a south-only flit
    cyc(1, 20'h00100, 64'h5555_AAAA_5555_AAAA, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      if (k == 7) chk("starve_pre9", 64'(starve_o), 64'd0);
      if (k == 8) chk("starve_9th",  64'(starve_o), 64'd1);
      cyc(0, '0, '0, 4'b0000);
    end
    cyc(0, '0, '0, 4'b0100);
    chk("starve_clr",   64'(starve_o), 64'd0);
    chk("starve_ready", 64'(in_ready), 64'd1);

    // Local-only flit is dropped; stray grant bit ignored
    cyc(1, 20'h30000, 64'h1, 4'b0000);
    chk("drop_pulse", 64'(drop_o),   64'd1);
    chk("drop_ready", 64'(in_ready), 64'd1);
    cyc(0, '0, '0, 4'b0000);
    chk("drop_once",  64'(drop_o),   64'd0);
    cyc(1, 20'h00001, 64'h2, 4'b0000);
    cyc(0, '0, '0, 4'b1001);
    chk("stray_rep",  64'(rep_cnt),  64'd7);

    // Reset while issuing
    cyc(1, 20'h00F00, 64'h3, 4'b0000);
    cyc(0, '0, '0, 4'b0000);
    gnt_i = 4'b0100;
    #1;
    chk("pre_rst_s", 64'(out_dst_s), 64'h00F00);
    rst_n = 1'b0;
    #1;
    chk("mrst_req",   64'(req_o),     64'd0);
    chk("mrst_dst_s", 64'(out_dst_s), 64'd0);
    chk("mrst_rep",   64'(rep_cnt),   64'd0);
    chk("mrst_ready", 64'(in_ready),  64'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, '0, '0, 4'b0100);

    // Randomized traffic with periodic grant droughts
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0:       rd = DW'($urandom) & 20'hF0000;
        1:       rd = DW'($urandom) & region_mask[$urandom_range(0, 3)];
        default: rd = DW'($urandom);
      endcase
      rg = 4'($urandom_range(0, 15));
      if ((k % 60) < 12 || $urandom_range(0, 9) < 3) rg = 4'd0;
      cyc(($urandom_range(0, 3) != 0), rd, {$urandom, $urandom}, rg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_inj_seq.md
Name: mc_inj_seq

Overview:
- Injection-side sequencer for multicast flits from the local PE into the bufferless multicast router.
- Holds one flit and requests every productive output port (N/E/S/W) each cycle.
- Retires granted destination regions, hands each granted port a pruned destination list, and releases the slot once every destination has been served.
- Sits between the PE inject interface and the router port allocator. Flags starvation so the router can reserve an injection slot.

Parameters:
- FLIT_W, 64, payload width carried alongside the destination list.
- DST_W, `DST_LIST_WIDTH, destination list width, partitioned by `N_MASK/`E_MASK/`S_MASK/`W_MASK/`L_MASK.
- STARVE_THRESH, 8, consecutive zero-grant ISSUE cycles before starve_o asserts; legal range 1..2^CNT_W-1.
- CNT_W, 4, starvation counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  PE presents a flit.
- in_ready  out  1  sequencer accepts a flit this cycle.
- in_dst  in  DST_W  destination list of the offered flit.
- in_data  in  FLIT_W  payload of the offered flit.
- req_o  out  4  port request vector, bit0=N, 1=E, 2=S, 3=W.
- gnt_i  in  4  same-cycle grant vector from the allocator.
- out_data  out  FLIT_W  held payload, shared by all replicas.
- out_dst_n/e/s/w  out  DST_W each  pruned destination list for that port's replica.
- starve_o  out  1  injection starving.
- drop_o  out  1  one-cycle pulse when a flit with no productive destination is discarded.
- rep_cnt  out  16  running count of replicas issued; wraps.

Behaviour:
- States: IDLE, ISSUE. Reset forces IDLE and clears every register:
  - in_ready=1 after reset; req_o=0, out_dst_*=0, out_data=0, starve_o=0, drop_o=0, rep_cnt=0.
- IDLE:
  - in_ready=1 (depends only on state, never on gnt_i).
  - On in_valid, latch in_dst into dst_rem and in_data into out_data.
  - If in_dst & (N|E|S|W masks) == 0, discard the flit instead: drop_o=1 next cycle, stay IDLE.
  - Otherwise go to ISSUE next cycle.
- ISSUE:
  - in_ready=0.
  - req_o[i] = |(dst_rem & MASK_i).
  - out_dst_x = dst_rem & MASK_x, valid only where the corresponding gnt_i bit is set; it is 0 wherever gnt_i is 0. Each replica carries only its own region.
  - Effective grant g = gnt_i & req_o. Grant bits outside req_o are ignored, and no replica is counted for them.
  - At the clock edge: dst_rem <= dst_rem & ~(OR of MASK_i for each set g[i]); rep_cnt += popcount(g), wrapping at 2^16.
  - If the new dst_rem has no N/E/S/W bits, go to IDLE. L-region bits are dropped silently.
- Latency and throughput:
  - A flit accepted at edge t is requested from cycle t+1.
  - A full grant at t+1 returns to IDLE at t+2, so peak throughput is 1 flit per 2 cycles.
- Starvation counter:
  - Increments on each ISSUE cycle with g==0 and saturates at STARVE_THRESH.
  - starve_o = (cnt == STARVE_THRESH), registered.
  - Cleared on any nonzero g and on leaving ISSUE.
- Simultaneous events: a partial grant in the same cycle starve would assert clears the counter, so starve_o stays 0.
- rst_n low mid-ISSUE aborts the held flit. No replica is emitted after reset and no drop_o pulse is produced.
- out_data stays stable through the whole ISSUE period.

Decomposition:
- Shared package (global.vh) holds:
  - `NUM_PORT, `DST_LIST_WIDTH, `N/E/S/W/L_MASK.
  - Port index constants N=0, E=1, S=2, W=3, L=4.
  - A 2-bit state encoding for IDLE/ISSUE.
- Natural sub-module: mc_port_req, a combinational unit that turns dst_rem into req_o, per-port out_dst and the retire mask. It is reused by the ejection-side sequencer.

Test Plan:
Bench build: DST_W=20, N=0x0000F, E=0x000F0, S=0x00F00, W=0x0F000, L=0xF0000.
- Unicast: in_dst=0x00010, gnt_i=4'b0010 in the first ISSUE cycle -> req_o=0010, out_dst_e=0x00010, rep_cnt=1, in_ready=1 the following cycle.
- Partial grant: in_dst=0x01231, gnt=0001 then 0100 then 1010 -> req_o 1111 then 1110 then 1010; out_dst_n=0x00001, out_dst_s=0x00200, out_dst_e=0x00030, out_dst_w=0x01000 in turn; rep_cnt=4; return to IDLE.
- Starvation: in_dst=0x00100, gnt_i=0 for 10 cycles -> starve_o=1 from the 9th ISSUE cycle on. A grant of 0100 clears starve_o next cycle and returns to IDLE.
- Drop/illegal: in_dst=0x30000 -> drop_o pulses once, in_ready stays 1, no req_o. With in_dst=0x00001 and gnt_i=1001, the W bit is ignored and rep_cnt increments by 1.
- Reset mid-op: rst_n low during ISSUE with dst_rem=0x00F00 -> req_o=0, out_dst_*=0, rep_cnt=0 immediately; IDLE with in_ready=1 after release.
